// File: rtl/regfile.sv
// Integer register file with a post-reset clear sequencer and two combinational read ports.
// Optional same-cycle write-through to the read ports: define REGFILE_BYPASS_EN.
module regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              ready_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= ADDR_W'(1);
      ready_o <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == '1) begin
            state   <= READY;
            ready_o <= 1'b1;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Single write port shared by the clear sequencer and write-back; entry 0 is never stored.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = waddr_i;
    mem_data = wdata_i;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_idx;
      mem_data = '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              en,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] d;
    d = '0;
    if ((state == READY) && en && (ra != '0)) begin
      d = stored;
`ifdef REGFILE_BYPASS_EN
      if (we_i && (waddr_i == ra)) begin
        d = wdata_i;
      end
`endif
    end
    return d;
  endfunction

  always_comb begin
    rdata1_o = read_port(re1_i, raddr1_i, mem[raddr1_i]);
    rdata2_o = read_port(re2_i, raddr2_i, mem[raddr2_i]);
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the driver queues expected read/ready values, the monitor checks them.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        re1_i = 1'b0;
  logic [4:0]  raddr1_i = '0;
  logic [31:0] rdata1_o;
  logic        re2_i = 1'b0;
  logic [4:0]  raddr2_i = '0;
  logic [31:0] rdata2_o;
  logic        ready_o;

  regfile #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        er;
  } exp_t;

  exp_t q[$];
  logic chk_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: the read outputs are combinational, so a check is presented every cycle the driver flags one.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (rdata1_o !== e.e1 || rdata2_o !== e.e2 || ready_o !== e.er) begin
          errors++;
          $display("FAIL %s: rdata1 got %h want %h, rdata2 got %h want %h, ready got %b want %b",
                   e.tag, rdata1_o, e.e1, rdata2_o, e.e2, ready_o, e.er);
        end
      end
    end
  end

  // Inputs set here take effect at the next edge; the check sees state after the edge just passed.
  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                      input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we_i = w; waddr_i = wa; wdata_i = wd;
    re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
    e.tag = tag; e.e1 = e1; e.e2 = e2; e.er = er;
    q.push_back(e);
    chk_valid = 1'b1;
  endtask

  // Caller has just issued a step whose edge sampled rst==0; this runs the 31 clear edges.
  // Writes to entry 1 are attempted throughout; they must be ignored in CLEAR.
  task automatic clear_run(input string tag);
    for (int j = 1; j <= 31; j++) begin
      step(1'b1, (j < 31), 5'd1, 32'hFFFF_FFFF, 1'b1, 5'(j), 1'b1, 5'd5,
           $sformatf("%s_edge%0d", tag, j), 32'h0, 32'h0, (j == 31));
    end
  endtask

  logic [31:0] byp_exp;

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'hA5A5_A5A5;
`else
    byp_exp = 32'h0000_0011;
`endif
    // Two reset cycles, reads enabled: outputs forced to 0 in CLEAR.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9, "rst0", 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9, "rst1", 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9, "rst_release", 32'h0, 32'h0, 1'b0);
    clear_run("clear1");

    for (int i = 1; i <= 31; i++) begin
      step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i),
           $sformatf("zero_rd%0d", i), 32'h0, 32'h0, 1'b1);
    end

    step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 1'b0, 5'd5, "wr_x5", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, "rd_x5", 32'hDEAD_BEEF, 32'h0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5, "rd_x5_re1_off", 32'h0, 32'hDEAD_BEEF, 1'b1);

    step(1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0, "wr_x0", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, "rd_x0", 32'h0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 5'd7, 32'h0000_0011, 1'b0, 5'd0, 1'b0, 5'd0, "wr_x7", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7, "bypass_x7", byp_exp, byp_exp, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, "rd_x7_after", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);

    step(1'b1, 1'b1, 5'd3, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0, "wr_x3", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 5'd4, 32'h0000_0002, 1'b0, 5'd0, 1'b0, 5'd0, "wr_x4", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4, "rd_x3_x4", 32'h1, 32'h2, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd4, "rd_x4_x4", 32'h2, 32'h2, 1'b1);

    // Reset during a clear at cycle 10, then a full clear must follow.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4, "rst2_assert", 32'h1, 32'h2, 1'b1);
    step(1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd4, "rst2_release", 32'h0, 32'h0, 1'b0);
    for (int j = 1; j <= 9; j++) begin
      step(1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd4,
           $sformatf("partial_edge%0d", j), 32'h0, 32'h0, 1'b0);
    end
    step(1'b0, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd4, "partial_edge10", 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1, 5'd4, "rst3_release", 32'h0, 32'h0, 1'b0);
    clear_run("clear2");

    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd3, "post_clear_x1_x3", 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd7, "post_clear_x4_x7", 32'h0, 32'h0, 1'b1);

    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    re1_i = 1'b0;
    re2_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
